// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor.
// One full-adder bit is evaluated per clock, LSB first, with a single
// registered carry. An accepted operand pair spends exactly WIDTH cycles in
// RUN and then waits in DONE until the consumer takes the result. Subtraction
// is a + ~b + 1: the captured B operand is inverted and the carry starts at 1.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  // The counter counts 0..WIDTH and never wraps during an operation.
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  // Full adder on the current LSBs and the registered carry.
  logic sum_bit;
  logic carry_out;
  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // Sum bits enter at the MSB so that after WIDTH shifts s holds the result
  // in natural bit order. Written as shifts so that WIDTH=1 stays legal.
  logic [WIDTH-1:0] s_shift;
  assign s_shift = (s_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          co_d    = carry_out;
          ov_d    = carry_q ^ carry_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers here are small flops (no RAM), so each one is
    // reset; non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8.
// Inputs change and outputs are sampled #1 after the rising edge or on the
// falling edge, never at the active edge itself.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  int n_asserts = 0;
  int n_fails   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency and result. With noise set,
  // in_valid/out_ready are driven with junk during RUN (must be ignored).
  // hold = number of DONE cycles with out_ready=0 and in_valid pulses.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_sub, input logic [7:0] exp_s, input logic exp_co,
                        input logic exp_ov, input bit noise, input int hold);
    int n;
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    sub      = op_sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, " in_ready run"}, 64'(in_ready), 64'd0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (out_valid) break;
      if (noise) begin
        in_valid  = 1'b1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        sub       = ~sub;
        out_ready = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // Accepting edge plus WIDTH RUN edges: out_valid is seen WIDTH edges
    // after the accepting edge (9 edges counting the accepting one).
    check({tag, " latency"}, 64'(n), 64'(WIDTH));
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " s"}, 64'(s), 64'(exp_s));
    check({tag, " co"}, 64'(co), 64'(exp_co));
    check({tag, " ov"}, 64'(ov), 64'(exp_ov));
    check({tag, " in_ready done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a        = 8'hA5 ^ 8'(i);
      b        = 8'h3C;
      @(posedge clk);
      #1;
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold s"}, 64'({s, co, ov}), 64'({exp_s, exp_co, exp_ov}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " released out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " released in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " released s/co/ov"}, 64'({s, co, ov}), 64'({exp_s, exp_co, exp_ov}));
  endtask

  initial begin
    // Reset state.
    #2;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset s/co/ov", 64'({s, co, ov}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic vectors.
    run_op("add 0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 0);
    run_op("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    run_op("sub 05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
    run_op("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0);
    run_op("noise 12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 0);

    // Backpressure: 5 DONE cycles with out_ready=0 and in_valid pulses.
    run_op("bp 40-40", 8'h40, 8'h40, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5);

    // Leaves co=1, ov=1 so the reset below must visibly clear them.
    run_op("add 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);

    // Reset during RUN cycle 4.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h55;
    b        = 8'h22;
    sub      = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid-run s before reset", 64'(s != 8'h00), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset s/co/ov", 64'({s, co, ov}), 64'd0);
    check("mid-run reset out_valid", 64'(out_valid), 64'd0);
    check("mid-run reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("held reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("discarded no out_valid", 64'(out_valid), 64'd0);
    end

    // New operation after reset completes normally.
    run_op("post-reset 10-20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
